// File: rtl/timer_intr_gen.sv
// timer_intr_gen: 64-bit machine timer with prescaler, compare register and level interrupt.
// Single-beat bus slave; every request is acked on the following cycle.
module timer_intr_gen #(
    parameter int DW    = 32,
    parameter int ADDRW = 8,
    parameter int PSW   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [ADDRW-1:0] addr_i,
    input  logic [DW-1:0]    wdata_i,
    output logic             ack_o,
    output logic [DW-1:0]    rdata_o,
    output logic             timer_irq_o
);
    localparam logic [ADDRW-3:0] W_MLO  = (ADDRW-2)'(0);
    localparam logic [ADDRW-3:0] W_MHI  = (ADDRW-2)'(1);
    localparam logic [ADDRW-3:0] W_CLO  = (ADDRW-2)'(2);
    localparam logic [ADDRW-3:0] W_CHI  = (ADDRW-2)'(3);
    localparam logic [ADDRW-3:0] W_CTRL = (ADDRW-2)'(4);
    localparam logic [ADDRW-3:0] W_PRES = (ADDRW-2)'(5);
    localparam logic [ADDRW-3:0] W_STAT = (ADDRW-2)'(6);

    logic [63:0]      mtime, mtimecmp;
    logic [PSW-1:0]   presc, pcnt;
    logic [31:0]      hi_shadow;
    logic             en, ie;
    logic [ADDRW-3:0] wi;
    logic             wr, rd, match, tick;
    logic [DW-1:0]    rd_val;

    assign wi    = addr_i[ADDRW-1:2];
    assign wr    = req_i & we_i;
    assign rd    = req_i & ~we_i;
    assign match = mtime >= mtimecmp;
    assign tick  = en & (pcnt == presc);

    always_comb begin
        rd_val = '0;
        case (wi)
            W_MLO:   rd_val = mtime[31:0];
            W_MHI:   rd_val = hi_shadow;
            W_CLO:   rd_val = mtimecmp[31:0];
            W_CHI:   rd_val = mtimecmp[63:32];
            W_CTRL:  rd_val = DW'({ie, en});
            W_PRES:  rd_val = DW'(presc);
            W_STAT:  rd_val = DW'(match);
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime       <= '0;
            mtimecmp    <= '1;
            presc       <= '0;
            pcnt        <= '0;
            hi_shadow   <= '0;
            en          <= 1'b0;
            ie          <= 1'b0;
            ack_o       <= 1'b0;
            rdata_o     <= '0;
            timer_irq_o <= 1'b0;
        end else begin
            ack_o       <= req_i;
            rdata_o     <= rd ? rd_val : '0;
            timer_irq_o <= ie & match;
            if (rd && wi == W_MLO)
                hi_shadow <= mtime[63:32];
            // a bus write to either mtime half suppresses that cycle's increment
            if (wr && wi == W_MLO)
                mtime <= {mtime[63:32], wdata_i};
            else if (wr && wi == W_MHI)
                mtime <= {wdata_i, mtime[31:0]};
            else if (tick)
                mtime <= mtime + 64'd1;
            if (wr && wi == W_CLO)
                mtimecmp[31:0] <= wdata_i;
            if (wr && wi == W_CHI)
                mtimecmp[63:32] <= wdata_i;
            if (wr && wi == W_CTRL) begin
                en <= wdata_i[0];
                ie <= wdata_i[1];
            end
            if (wr && wi == W_PRES)
                presc <= wdata_i[PSW-1:0];
            if (wr && wi == W_PRES)
                pcnt <= '0;
            else if (en)
                pcnt <= tick ? '0 : pcnt + PSW'(1);
        end
    end
endmodule

// File: tb/tb_timer_intr_gen.sv
// tb_timer_intr_gen: directed tests for timer_intr_gen.
module tb_timer_intr_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        ack;
    logic [31:0] rdata;
    logic        irq;
    int          errors = 0;
    int          checks = 0;

    timer_intr_gen dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .timer_irq_o(irq)
    );

    always #5 clk = ~clk;

    // called at a negedge: presents one request, returns at the next negedge
    task automatic access(input logic w, input logic [7:0] a, input logic [31:0] d,
                          output logic k, output logic [31:0] q);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        k = ack; q = rdata;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic k;
        logic [31:0] q;
        access(1'b1, a, d, k, q);
    endtask

    task automatic check_regs(input string tag);
        logic k;
        logic [31:0] q, exp;
        for (int i = 0; i < 8; i++) begin
            access(1'b0, 8'(i * 4), 32'h0, k, q);
            exp = (i == 2 || i == 3) ? 32'hFFFF_FFFF : 32'h0;
            checks++;
            if (k !== 1'b1) begin
                errors++;
                $display("FAIL %s ack@%0h: got %b expected 1", tag, i * 4, k);
            end
            checks++;
            if (q !== exp) begin
                errors++;
                $display("FAIL %s rdata@%0h: got %h expected %h", tag, i * 4, q, exp);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL %s irq: got %b expected 0", tag, irq);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (ack !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b rdata=%h irq=%b expected 0/0/0", ack, rdata, irq);
        end
        rst = 1'b0;
        check_regs("reset");
    endtask

    task automatic test_prescaler();
        logic k;
        logic [31:0] a, b, c;
        wr(8'h14, 32'd3);
        wr(8'h10, 32'h1);
        repeat (40) @(negedge clk);
        access(1'b0, 8'h00, 32'h0, k, a);
        checks++;
        if (a !== 32'd10) begin
            errors++;
            $display("FAIL presc_count: got %0d expected 10", a);
        end
        wr(8'h10, 32'h0);
        access(1'b0, 8'h00, 32'h0, k, b);
        repeat (20) @(negedge clk);
        access(1'b0, 8'h00, 32'h0, k, c);
        checks++;
        if (b !== 32'd10 || c !== 32'd10) begin
            errors++;
            $display("FAIL presc_freeze: got %0d,%0d expected 10,10", b, c);
        end
    endtask

    task automatic test_carry();
        logic k;
        logic [31:0] lo, hi;
        wr(8'h00, 32'hFFFF_FFFE);
        wr(8'h04, 32'h0);
        wr(8'h14, 32'h0);
        wr(8'h10, 32'h1);
        repeat (3) @(negedge clk);
        access(1'b0, 8'h00, 32'h0, k, lo);
        access(1'b0, 8'h04, 32'h0, k, hi);
        checks++;
        if (lo !== 32'h1) begin
            errors++;
            $display("FAIL carry_lo: got %h expected 00000001", lo);
        end
        checks++;
        if (hi !== 32'h1) begin
            errors++;
            $display("FAIL carry_hi_shadow: got %h expected 00000001", hi);
        end
        wr(8'h10, 32'h0);
    endtask

    task automatic test_irq();
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h0);
        wr(8'h0C, 32'h0);
        wr(8'h08, 32'd20);
        wr(8'h14, 32'h0);
        wr(8'h10, 32'h3);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k >= 19) begin
                checks++;
                if (irq !== (k >= 21)) begin
                    errors++;
                    $display("FAIL irq_rise k=%0d: got %b expected %b", k, irq, k >= 21);
                end
            end
        end
        wr(8'h08, 32'd1000);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_hold_on_write_edge: got %b expected 1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall: got %b expected 0", irq);
        end
    endtask

    task automatic test_ie_off();
        logic k;
        logic [31:0] q;
        wr(8'h08, 32'd10);
        wr(8'h10, 32'h1);
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL ie_off_irq: got %b expected 0", irq);
        end
        access(1'b0, 8'h18, 32'h0, k, q);
        checks++;
        if (q !== 32'h1) begin
            errors++;
            $display("FAIL status_raw: got %h expected 00000001", q);
        end
        wr(8'h10, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [5] = '{32'h0, 32'h0, 32'h5, 32'h0, 32'h0};
        logic        w [5]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  a [5]   = '{8'h14, 8'h14, 8'h14, 8'h1C, 8'h1C};
        for (int i = 0; i < 5; i++) begin
            req = 1'b1; we = w[i]; addr = a[i]; wdata = w[i] ? ((i == 1) ? 32'h5 : 32'hFFFF_FFFF) : 32'h0;
            @(negedge clk);
            checks++;
            if (ack !== 1'b1 || rdata !== exp[i]) begin
                errors++;
                $display("FAIL b2b[%0d]: got ack=%b rdata=%h expected 1/%h", i, ack, rdata, exp[i]);
            end
        end
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_ack: got %b expected 0", ack);
        end
        wr(8'h08, 32'h0);
        wr(8'h10, 32'h3);
        repeat (3) @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 8'h0C; rst = 1'b1;
        @(negedge clk);
        req = 1'b0;
        checks++;
        if (ack !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_drop_ack: got ack=%b rdata=%h irq=%b expected 0/0/0", ack, rdata, irq);
        end
        rst = 1'b0;
        @(negedge clk);
        check_regs("post_reset");
    endtask

    initial begin
        test_reset();
        test_prescaler();
        test_carry();
        test_irq();
        test_ie_off();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
